// File: rtl/road_car_tracker.sv
// road_car_tracker
// ----------------
// Game-state owner on the car side of the move-check interface. It keeps the
// scrolling obstacle road, the car lane and the lives/score counters. Each
// game step strobes the move checker, waits a fixed latency for its
// {hit, left, right} verdict, then applies it by moving the car, charging a
// life and scrolling the road.
//
// Ports:
//   clk         system clock
//   reset       synchronous active-high reset
//   tick        game-step request, honoured only while idle
//   newRow      obstacle row entering road row 0, sampled in APPLY
//   moveResult  checker verdict: [2] hit, [1:0] 10=left, 01=right, 00=none
//   checkStep   one-cycle strobe to the checker step input
//   nextRow     road row CAR_ROW-1 (row ahead of the car)
//   headRow     road row CAR_ROW (car head)
//   tailRow     road row CAR_ROW+1 (car tail)
//   position    current car lane (5 = leftmost)
//   lives       remaining lives
//   score       completed steps
//   roadFlat    all rows, row r at bits [6r+5:6r]
//   busy        high while a step is in flight
//   gameOver    high once lives reach zero
module road_car_tracker #(
    parameter int ROWS       = 8,
    parameter int CAR_ROW    = 6,
    parameter int START_POS  = 2,
    parameter int LIVES      = 3,
    parameter int RESULT_LAT = 2,
    parameter int SCORE_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic [5:0]           newRow,
    input  logic [2:0]           moveResult,
    output logic                 checkStep,
    output logic [5:0]           nextRow,
    output logic [5:0]           headRow,
    output logic [5:0]           tailRow,
    output logic [2:0]           position,
    output logic [3:0]           lives,
    output logic [SCORE_W-1:0]   score,
    output logic [6*ROWS-1:0]    roadFlat,
    output logic                 busy,
    output logic                 gameOver
);

    localparam int CNT_W = (RESULT_LAT > 1) ? $clog2(RESULT_LAT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STROBE = 3'd1,
        S_WAIT   = 3'd2,
        S_APPLY  = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    state_t               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [5:0]           row_r [ROWS];
    logic [2:0]           position_r;
    logic [3:0]           lives_r;
    logic [SCORE_W-1:0]   score_r;
    logic                 check_step_r;
    logic                 busy_r;
    logic                 game_over_r;

    logic [2:0]           position_next_s;
    logic [3:0]           lives_next_s;

    // Lane after applying the checker's move request; edge lanes clamp.
    always_comb begin
        position_next_s = position_r;
        case (moveResult[1:0])
            2'b10: begin
                if (position_r < 3'd5) begin
                    position_next_s = position_r + 3'd1;
                end else begin
                    position_next_s = position_r;
                end
            end
            2'b01: begin
                if (position_r > 3'd0) begin
                    position_next_s = position_r - 3'd1;
                end else begin
                    position_next_s = position_r;
                end
            end
            default: position_next_s = position_r;
        endcase
    end

    // Lives after a possible hit, saturating at zero.
    always_comb begin
        lives_next_s = lives_r;
        if (moveResult[2] && (lives_r != 4'd0)) begin
            lives_next_s = lives_r - 4'd1;
        end else begin
            lives_next_s = lives_r;
        end
    end

    // Step sequencer and all game state; road and lane only change in APPLY,
    // so the rows seen by the checker stay stable for the whole step.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_IDLE;
            cnt_r        <= '0;
            position_r   <= 3'(START_POS);
            lives_r      <= 4'(LIVES);
            score_r      <= '0;
            check_step_r <= 1'b0;
            busy_r       <= 1'b0;
            game_over_r  <= 1'b0;
            for (int i = 0; i < ROWS; i++) begin
                row_r[i] <= 6'd0;
            end
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (tick) begin
                        state_r      <= S_STROBE;
                        check_step_r <= 1'b1;
                        busy_r       <= 1'b1;
                    end else begin
                        state_r      <= S_IDLE;
                    end
                end
                S_STROBE: begin
                    check_step_r <= 1'b0;
                    cnt_r        <= CNT_W'(RESULT_LAT - 1);
                    // A one-cycle latency has no WAIT cycles at all.
                    if (RESULT_LAT <= 1) begin
                        state_r <= S_APPLY;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    // Leave when the count reaches zero so APPLY lands exactly
                    // RESULT_LAT cycles after the strobe.
                    if (cnt_r <= CNT_W'(1)) begin
                        state_r <= S_APPLY;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                S_APPLY: begin
                    position_r <= position_next_s;
                    lives_r    <= lives_next_s;
                    row_r[0]   <= newRow;
                    for (int i = 1; i < ROWS; i++) begin
                        row_r[i] <= row_r[i-1];
                    end
                    busy_r <= 1'b0;
                    if (lives_next_s == 4'd0) begin
                        state_r     <= S_OVER;
                        game_over_r <= 1'b1;
                    end else begin
                        state_r     <= S_IDLE;
                        score_r     <= score_r + SCORE_W'(1);
                    end
                end
                S_OVER: begin
                    state_r     <= S_OVER;
                    game_over_r <= 1'b1;
                end
                default: begin
                    state_r      <= S_IDLE;
                    check_step_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    // Flatten the road for observers; row r occupies bits [6r+5:6r].
    always_comb begin
        roadFlat = {(6*ROWS){1'b0}};
        for (int r = 0; r < ROWS; r++) begin
            roadFlat[6*r +: 6] = row_r[r];
        end
    end

    assign nextRow   = row_r[CAR_ROW-1];
    assign headRow   = row_r[CAR_ROW];
    assign tailRow   = row_r[CAR_ROW+1];
    assign position  = position_r;
    assign lives     = lives_r;
    assign score     = score_r;
    assign checkStep = check_step_r;
    assign busy      = busy_r;
    assign gameOver  = game_over_r;

endmodule

// File: tb/tb_road_car_tracker.sv
module tb_road_car_tracker;

    localparam int ROWS       = 8;
    localparam int CAR_ROW    = 6;
    localparam int START_POS  = 2;
    localparam int LIVES      = 3;
    localparam int RESULT_LAT = 2;
    localparam int SCORE_W    = 16;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                tick = 1'b0;
    logic [5:0]          newRow = 6'd0;
    logic [2:0]          moveResult = 3'd0;
    logic                checkStep;
    logic [5:0]          nextRow, headRow, tailRow;
    logic [2:0]          position;
    logic [3:0]          lives;
    logic [SCORE_W-1:0]  score;
    logic [6*ROWS-1:0]   roadFlat;
    logic                busy, gameOver;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: road as a list of rows, top row first.
    logic [5:0] m_road [$];
    int         m_pos, m_lives, m_score;
    bit         m_over;

    road_car_tracker #(
        .ROWS(ROWS), .CAR_ROW(CAR_ROW), .START_POS(START_POS),
        .LIVES(LIVES), .RESULT_LAT(RESULT_LAT), .SCORE_W(SCORE_W)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .newRow(newRow),
        .moveResult(moveResult), .checkStep(checkStep), .nextRow(nextRow),
        .headRow(headRow), .tailRow(tailRow), .position(position),
        .lives(lives), .score(score), .roadFlat(roadFlat), .busy(busy),
        .gameOver(gameOver)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_road.delete();
        for (int i = 0; i < ROWS; i++) m_road.push_back(6'd0);
        m_pos = START_POS; m_lives = LIVES; m_score = 0; m_over = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] mr, input logic [5:0] nr);
        if (m_over) return;
        if (mr[1:0] == 2'b10 && m_pos < 5) m_pos = m_pos + 1;
        if (mr[1:0] == 2'b01 && m_pos > 0) m_pos = m_pos - 1;
        if (mr[2] && m_lives > 0) m_lives = m_lives - 1;
        m_road.push_front(nr);
        void'(m_road.pop_back());
        if (m_lives != 0) m_score = (m_score + 1) % (1 << SCORE_W);
        else m_over = 1'b1;
    endtask

    function automatic logic [6*ROWS-1:0] model_flat();
        logic [6*ROWS-1:0] f = '0;
        for (int r = 0; r < ROWS; r++) f[6*r +: 6] = m_road[r];
        return f;
    endfunction

    task automatic check_state(input string ctx);
        chk({ctx, ".position"}, 64'(position), 64'(m_pos));
        chk({ctx, ".lives"}, 64'(lives), 64'(m_lives));
        chk({ctx, ".score"}, 64'(score), 64'(m_score));
        chk({ctx, ".gameOver"}, 64'(gameOver), 64'(m_over));
        chk({ctx, ".busy"}, 64'(busy), 64'd0);
        chk({ctx, ".headRow"}, 64'(headRow), 64'(m_road[CAR_ROW]));
        chk({ctx, ".nextRow"}, 64'(nextRow), 64'(m_road[CAR_ROW-1]));
        chk({ctx, ".tailRow"}, 64'(tailRow), 64'(m_road[CAR_ROW+1]));
        chk({ctx, ".roadFlat"}, 64'(roadFlat), 64'(model_flat()));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; tick = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One game step: a single-cycle tick, then follow the step to idle.
    task automatic do_step(input string ctx, input logic [2:0] mr,
                           input logic [5:0] nr, input bit repulse);
        int  lat = 0;
        int  strobes = 0;
        bit  exp_run = !m_over;
        tick = 1'b1; moveResult = mr; newRow = nr;
        @(posedge clk); #1;
        tick = 1'b0;
        while (busy && lat < 20) begin
            if (checkStep) strobes++;
            chk({ctx, ".stable_next"}, 64'(nextRow), 64'(m_road[CAR_ROW-1]));
            chk({ctx, ".stable_pos"}, 64'(position), 64'(m_pos));
            tick = repulse && (lat == 1);
            @(posedge clk); #1;
            tick = 1'b0;
            lat++;
        end
        chk({ctx, ".latency"}, 64'(lat), exp_run ? 64'(RESULT_LAT + 1) : 64'd0);
        chk({ctx, ".strobes"}, 64'(strobes), exp_run ? 64'd1 : 64'd0);
        model_step(mr, nr);
        check_state(ctx);
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_state("reset");
        chk("reset.checkStep", 64'(checkStep), 64'd0);

        // Basic step with an entering obstacle row.
        do_step("basic", 3'b000, 6'b100001, 1'b0);
        chk("basic.row0", 64'(roadFlat[5:0]), 64'(6'b100001));
        chk("basic.score1", 64'(score), 64'd1);

        // Lane moves and edge clamping.
        for (int k = 0; k < 4; k++) do_step("left", 3'b010, 6'd0, 1'b0);
        chk("edge.left5", 64'(position), 64'd5);
        for (int k = 0; k < 6; k++) do_step("right", 3'b001, 6'd0, 1'b0);
        chk("edge.right0", 64'(position), 64'd0);
        do_step("nomove11", 3'b011, 6'd0, 1'b0);

        // Move combined with hit.
        do_reset();
        do_step("hitmove", 3'b110, 6'd0, 1'b0);
        chk("hitmove.pos3", 64'(position), 64'd3);
        chk("hitmove.lives2", 64'(lives), 64'd2);

        // Three hits end the game; later ticks are ignored.
        do_reset();
        for (int k = 0; k < 3; k++) do_step("hits", 3'b100, 6'd5, 1'b0);
        chk("over.score2", 64'(score), 64'd2);
        chk("over.flag", 64'(gameOver), 64'd1);
        for (int k = 0; k < 2; k++) do_step("frozen", 3'b110, 6'h3f, 1'b0);

        // Obstacle travels down to the car.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            do_step("scroll", 3'b000, (k == 0) ? 6'b000100 : 6'd0, 1'b0);
            if (k == 6) chk("scroll.head7", 64'(headRow), 64'(6'b000100));
            if (k == 7) chk("scroll.tail8", 64'(tailRow), 64'(6'b000100));
        end

        // Tick re-pulsed mid-step is dropped.
        do_reset();
        do_step("repulse", 3'b000, 6'd1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("repulse.score", 64'(score), 64'd1);
        chk("repulse.idle", 64'(busy), 64'd0);

        // Reset in the middle of a step aborts it.
        do_reset();
        tick = 1'b1; moveResult = 3'b110; newRow = 6'h3f;
        @(posedge clk); #1;
        tick = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        check_state("midreset");
        chk("midreset.checkStep", 64'(checkStep), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        check_state("midreset.after");

        // Randomized play against the model.
        do_reset();
        for (int k = 0; k < 150; k++) begin
            logic [2:0] mr;
            mr = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) mr[2] = 1'b1;
            do_step("rand", mr, 6'($urandom & 32'h3f), 1'b0);
            if (m_over && $urandom_range(0, 1) == 1) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
